// File: rtl/to_lower_stream.sv
// to_lower_stream
//   Streaming ASCII lower-case converter with a small output FIFO.
//   Bytes in 'A'..'Z' (0x41..0x5A) get bit 5 set when they are pushed.
//   All other byte values are stored unchanged.
//   A saturating counter tracks how many accepted bytes were converted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush of FIFO and counter (highest priority)
//   in_valid   producer offers in_data
//   in_ready   a byte can be accepted this cycle
//   in_data    ASCII byte from the producer
//   out_valid  FIFO head is valid
//   out_ready  consumer takes the head this cycle
//   out_data   converted byte at the FIFO head (0x00 while empty)
//   conv_count number of accepted bytes that were converted (saturating)
//   level      current FIFO occupancy, 0..DEPTH
module to_lower_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [CNT_W-1:0]           conv_count,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // True for the upper-case letters 'A'..'Z'.
  function automatic logic is_upper(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  // Lower-case mapping applied on push.
  function automatic logic [7:0] to_lower(input logic [7:0] b);
    if (is_upper(b)) begin
      return b | 8'h20;
    end else begin
      return b;
    end
  endfunction

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_nxt_s;
  logic [CNT_W-1:0] conv_count_r;
  // Low while in reset and until the first edge after release, so that
  // in_ready stays low through reset even though the FIFO is empty.
  logic             run_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;

  assign in_ready_s  = run_r && (level_r != FULL_LVL) && !clear;
  assign out_valid_s = (level_r != {LVL_W{1'b0}});
  assign push_s      = in_valid && in_ready_s;
  assign pop_s       = out_valid_s && out_ready;

  // Next occupancy from the push/pop pair.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers, occupancy, counter and run flag; clear overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      level_r      <= {LVL_W{1'b0}};
      conv_count_r <= {CNT_W{1'b0}};
      run_r        <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (clear) begin
        rd_ptr_r     <= {PTR_W{1'b0}};
        wr_ptr_r     <= {PTR_W{1'b0}};
        level_r      <= {LVL_W{1'b0}};
        conv_count_r <= {CNT_W{1'b0}};
      end else begin
        level_r <= level_nxt_s;
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        if (push_s && is_upper(in_data) && (conv_count_r != CNT_MAX)) begin
          conv_count_r <= conv_count_r + CNT_W'(1);
        end
      end
    end
  end

  // FIFO storage; not reset because it is masked at out_data while empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= to_lower(in_data);
    end
  end

  // Head byte, forced to zero while the FIFO is empty.
  always_comb begin
    out_data = 8'h00;
    if (out_valid_s) begin
      out_data = mem_r[rd_ptr_r];
    end else begin
      out_data = 8'h00;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign conv_count = conv_count_r;
  assign level      = level_r;

endmodule

// File: tb/tb_to_lower_stream.sv
// Directed, table-driven bench for to_lower_stream (DEPTH=4, CNT_W=16),
// plus a second instance with a 4-bit counter for the saturation case.
module tb_to_lower_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [15:0] conv_count;
  logic [2:0]  level;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_data;
  logic [3:0]  s_conv_count;
  logic [2:0]  s_level;

  int n_cmp = 0;
  int n_bad = 0;
  logic rdy_pre;

  always #5 clk = ~clk;

  to_lower_stream #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .conv_count(conv_count), .level(level)
  );

  to_lower_stream #(.DEPTH(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .conv_count(s_conv_count), .level(s_level)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [2:0] exp_lvl;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, sample in_ready before the edge, then settle after it.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
    rdy_pre = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [7:0] od,
                         input logic [2:0] lvl, input logic [15:0] cnt);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_data"}, 32'(out_data), 32'(od));
    chk({tag, ".level"}, 32'(level), 32'(lvl));
    chk({tag, ".conv_count"}, 32'(conv_count), 32'(cnt));
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy, input logic rdy,
                     input logic ov, input logic [7:0] od, input logic [2:0] lvl,
                     input logic [15:0] cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.exp_rdy = rdy;
    v.exp_ov = ov; v.exp_od = od; v.exp_lvl = lvl; v.exp_cnt = cnt;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // "AZaz@[" with out_ready high: one cycle latency, streaming.
    add(1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 8'h61, 3'd1, 16'd1);
    add(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h7A, 3'd1, 16'd2);
    add(1'b1, 8'h61, 1'b1, 1'b1, 1'b1, 8'h61, 3'd1, 16'd2);
    add(1'b1, 8'h7A, 1'b1, 1'b1, 1'b1, 8'h7A, 3'd1, 16'd2);
    add(1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 8'h40, 3'd1, 16'd2);
    add(1'b1, 8'h5B, 1'b1, 1'b1, 1'b1, 8'h5B, 3'd1, 16'd2);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 16'd2);
    // "HELLOW" with out_ready low: fills at 4, head stable, O/W refused.
    add(1'b1, 8'h48, 1'b0, 1'b1, 1'b1, 8'h68, 3'd1, 16'd3);
    add(1'b1, 8'h45, 1'b0, 1'b1, 1'b1, 8'h68, 3'd2, 16'd4);
    add(1'b1, 8'h4C, 1'b0, 1'b1, 1'b1, 8'h68, 3'd3, 16'd5);
    add(1'b1, 8'h4C, 1'b0, 1'b1, 1'b1, 8'h68, 3'd4, 16'd6);
    add(1'b1, 8'h4F, 1'b0, 1'b0, 1'b1, 8'h68, 3'd4, 16'd6);
    add(1'b1, 8'h57, 1'b0, 1'b0, 1'b1, 8'h68, 3'd4, 16'd6);
    // Drain: first pop from full cannot push; in_ready back next cycle.
    add(1'b1, 8'h4F, 1'b1, 1'b0, 1'b1, 8'h65, 3'd3, 16'd6);
    add(1'b1, 8'h4F, 1'b1, 1'b1, 1'b1, 8'h6C, 3'd3, 16'd7);
    add(1'b1, 8'h57, 1'b1, 1'b1, 1'b1, 8'h6C, 3'd3, 16'd8);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h6F, 3'd2, 16'd8);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 3'd1, 16'd8);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 16'd8);

    // Reset state
    rst_n = 1'b0;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    chk_out("reset", 1'b0, 8'h00, 3'd0, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].iv, vq[i].d, vq[i].ordy, 1'b0);
      chk($sformatf("vec%0d.in_ready", i), 32'(rdy_pre), 32'(vq[i].exp_rdy));
      chk_out($sformatf("vec%0d", i), vq[i].exp_ov, vq[i].exp_od, vq[i].exp_lvl, vq[i].exp_cnt);
    end

    // Level 2 with simultaneous push/pop for 10 cycles (pointers wrap).
    step(1'b1, 8'h41, 1'b0, 1'b0);
    chk_out("pp_pre0", 1'b1, 8'h61, 3'd1, 16'd9);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    chk_out("pp_pre1", 1'b1, 8'h61, 3'd2, 16'd10);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 8'(8'h43 + j), 1'b1, 1'b0);
      chk($sformatf("pp%0d.in_ready", j), 32'(rdy_pre), 32'd1);
      chk_out($sformatf("pp%0d", j), 1'b1, 8'(8'h62 + j), 3'd2, 16'(11 + j));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("pp_drain0", 1'b1, 8'h6C, 3'd1, 16'd20);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("pp_drain1", 1'b0, 8'h00, 3'd0, 16'd20);

    // Saturation on the 4-bit counter instance: 14 Q, then Q,R,S hold at 15.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("sat_clear.small_cnt", 32'(s_conv_count), 32'd0);
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 8'h51, 1'b1, 1'b0);
      chk($sformatf("sat_fill%0d", k), 32'(s_conv_count), 32'(k + 1));
    end
    step(1'b1, 8'h51, 1'b1, 1'b0);
    chk("sat_Q", 32'(s_conv_count), 32'd15);
    step(1'b1, 8'h52, 1'b1, 1'b0);
    chk("sat_R", 32'(s_conv_count), 32'd15);
    step(1'b1, 8'h53, 1'b1, 1'b0);
    chk("sat_S", 32'(s_conv_count), 32'd15);
    chk("sat_S.small_out", 32'(s_out_data), 32'h73);
    chk("sat.main_cnt", 32'(conv_count), 32'd17);

    // Clear with level 3, count 5, in_valid and out_ready high.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h41, 1'b1, 1'b0);
    step(1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b1, 8'h43, 1'b1, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h45, 1'b0, 1'b0);
    chk_out("clr_pre", 1'b1, 8'h63, 3'd3, 16'd5);
    step(1'b1, 8'h46, 1'b1, 1'b1);
    chk("clr.in_ready", 32'(rdy_pre), 32'd0);
    chk_out("clr_post", 1'b0, 8'h00, 3'd0, 16'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_after.in_ready", 32'(rdy_pre), 32'd1);

    // Asynchronous reset mid-cycle with two bytes buffered.
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    chk_out("ar_pre", 1'b1, 8'h31, 3'd2, 16'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.in_ready", 32'(in_ready), 32'd0);
    chk_out("ar", 1'b0, 8'h00, 3'd0, 16'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_release.in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    chk("ar_push.in_ready", 32'(rdy_pre), 32'd1);
    chk_out("ar_push", 1'b1, 8'h31, 3'd1, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
